// File: rtl/tru_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package tru_pkg;

  localparam int XLEN = 32;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [31:0] PC_STEP = 32'd4;

  typedef enum logic [1:0] {
    REQ,
    WAIT,
    HOLD,
    DISCARD
  } fetch_state_t;

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory port: valid/ready request channel and valid-only response channel.
interface fetch_unit_if #(
  parameter int XLEN = 32
);

  logic            req_valid;
  logic            req_ready;
  logic [XLEN-1:0] req_addr;
  logic            resp_valid;
  logic [XLEN-1:0] resp_data;

  modport master (
    output req_valid,
    output req_addr,
    input  req_ready,
    input  resp_valid,
    input  resp_data
  );

  modport slave (
    input  req_valid,
    input  req_addr,
    output req_ready,
    output resp_valid,
    output resp_data
  );

endinterface

// File: rtl/fetch_hold_buf.sv
// One-entry {pc, instr} buffer that parks a response arriving while decode is stalled.
module fetch_hold_buf #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic            clear,
  input  logic [XLEN-1:0] pc_in,
  input  logic [XLEN-1:0] instr_in,
  output logic            full,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] instr
);

  logic            full_reg;
  logic [XLEN-1:0] pc_reg;
  logic [XLEN-1:0] instr_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      full_reg  <= 1'b0;
      pc_reg    <= '0;
      instr_reg <= '0;
    end else if (clear) begin
      full_reg <= 1'b0;
    end else if (load) begin
      full_reg  <= 1'b1;
      pc_reg    <= pc_in;
      instr_reg <= instr_in;
    end
  end

  assign full  = full_reg;
  assign pc    = pc_reg;
  assign instr = instr_reg;

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage with a single outstanding imem request, stall buffering, stale-response
// discard after redirect, and the IF/ID pipeline register.
module fetch_unit #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall_if,
  input  logic            stall_id,
  input  logic            flush_if,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  fetch_unit_if.master    imem,
  output logic            id_valid,
  output logic [XLEN-1:0] id_pc,
  output logic [XLEN-1:0] id_instr
);

  import tru_pkg::*;

  fetch_state_t    state_reg, state_next;
  logic [XLEN-1:0] pc_reg, pc_next;
  logic [XLEN-1:0] redirect_target;
  logic [XLEN-1:0] pc_inc;
  logic            stall;
  logic            accept;
  logic            deliver;
  logic [XLEN-1:0] deliver_pc, deliver_instr;
  logic            buf_load, buf_clear, buf_full;
  logic [XLEN-1:0] buf_pc, buf_instr;
  logic            id_valid_reg;
  logic [XLEN-1:0] id_pc_reg, id_instr_reg;

  assign stall           = stall_if | stall_id;
  assign redirect_target = {redirect_pc[XLEN-1:2], 2'b00};
  assign pc_inc          = pc_reg + XLEN'(PC_STEP);

  assign imem.req_valid = (state_reg == REQ) && !rst;
  assign imem.req_addr  = pc_reg;
  assign accept         = imem.req_valid && imem.req_ready;

  fetch_hold_buf #(.XLEN(XLEN)) u_hold_buf (
    .clk      (clk),
    .rst      (rst),
    .load     (buf_load),
    .clear    (buf_clear),
    .pc_in    (pc_reg),
    .instr_in (imem.resp_data),
    .full     (buf_full),
    .pc       (buf_pc),
    .instr    (buf_instr)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= REQ;
      pc_reg    <= RESET_PC;
    end else begin
      state_reg <= state_next;
      pc_reg    <= pc_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    pc_next       = pc_reg;
    deliver       = 1'b0;
    deliver_pc    = pc_reg;
    deliver_instr = imem.resp_data;
    buf_load      = 1'b0;
    buf_clear     = 1'b0;
    case (state_reg)
      REQ: begin
        if (redirect_valid) begin
          pc_next    = redirect_target;
          state_next = accept ? DISCARD : REQ;
        end else if (accept) begin
          state_next = WAIT;
        end
      end
      WAIT: begin
        if (imem.resp_valid) begin
          if (redirect_valid) begin
            pc_next    = redirect_target;
            state_next = REQ;
          end else if (stall) begin
            buf_load   = 1'b1;
            state_next = HOLD;
          end else begin
            deliver    = 1'b1;
            pc_next    = pc_inc;
            state_next = REQ;
          end
        end else if (redirect_valid) begin
          // The request is still in flight; its response must be swallowed.
          pc_next    = redirect_target;
          state_next = DISCARD;
        end
      end
      HOLD: begin
        if (redirect_valid) begin
          buf_clear  = 1'b1;
          pc_next    = redirect_target;
          state_next = REQ;
        end else if (!stall) begin
          deliver       = 1'b1;
          deliver_pc    = buf_pc;
          deliver_instr = buf_instr;
          buf_clear     = 1'b1;
          pc_next       = pc_inc;
          state_next    = REQ;
        end
      end
      DISCARD: begin
        // A redirect coinciding with the stale response still retires that response.
        if (redirect_valid) begin
          pc_next = redirect_target;
        end
        if (imem.resp_valid) begin
          state_next = REQ;
        end
      end
      default: state_next = REQ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      id_valid_reg <= 1'b0;
      id_pc_reg    <= '0;
      id_instr_reg <= XLEN'(NOP_INSTR);
    end else if (flush_if) begin
      id_valid_reg <= 1'b0;
    end else if (stall_id) begin
      id_valid_reg <= id_valid_reg;
    end else if (deliver) begin
      id_valid_reg <= 1'b1;
      id_pc_reg    <= deliver_pc;
      id_instr_reg <= deliver_instr;
    end else begin
      id_valid_reg <= 1'b0;
    end
  end

  assign id_valid = id_valid_reg;
  assign id_pc    = id_pc_reg;
  assign id_instr = id_instr_reg;

  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(stall_id && flush_if))
        else $error("fetch_unit: stall_id and flush_if asserted together");
      assert (!(imem.resp_valid && (state_reg == REQ || state_reg == HOLD)))
        else $error("fetch_unit: response with no request outstanding");
      assert (!(state_reg == HOLD && !buf_full))
        else $error("fetch_unit: HOLD state with empty hold buffer");
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: behavioural imem responder plus a queue of expected IF/ID deliveries.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall_if;
  logic        stall_id;
  logic        flush_if;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_valid;
  logic [31:0] id_pc;
  logic [31:0] id_instr;

  always #5 clk = ~clk;

  fetch_unit_if #(.XLEN(32)) imem_bus ();

  fetch_unit #(.XLEN(32), .RESET_PC(32'h0000_0000)) dut (
    .clk            (clk),
    .rst            (rst),
    .stall_if       (stall_if),
    .stall_id       (stall_id),
    .flush_if       (flush_if),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem           (imem_bus),
    .id_valid       (id_valid),
    .id_pc          (id_pc),
    .id_instr       (id_instr)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  exp_t        exp_q[$];
  int          n_tests = 0;
  int          n_fail = 0;
  int          mem_lat = 1;
  bit          mem_ready = 1'b1;
  bit          pend = 1'b0;
  logic [31:0] pend_addr = '0;
  int          pend_cnt = 0;
  bit          stall_id_edge = 1'b0;

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  task automatic push_exp(input logic [31:0] pc);
    exp_t e;
    e.pc    = pc;
    e.instr = instr_of(pc);
    exp_q.push_back(e);
  endtask

  // Memory responder: answers mem_lat cycles after an accepted request.
  task automatic mem_drive();
    imem_bus.resp_valid = 1'b0;
    imem_bus.req_ready  = mem_ready;
    if (rst) begin
      pend = 1'b0;
      return;
    end
    if (pend) begin
      if (pend_cnt == 0) begin
        imem_bus.resp_valid = 1'b1;
        imem_bus.resp_data  = instr_of(pend_addr);
        pend = 1'b0;
      end else begin
        pend_cnt--;
      end
    end
    if (imem_bus.req_valid && mem_ready) begin
      pend      = 1'b1;
      pend_addr = imem_bus.req_addr;
      pend_cnt  = mem_lat - 1;
    end
  endtask

  task automatic monitor();
    exp_t e;
    if (id_valid && !stall_id_edge) begin
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL delivery: unexpected id_pc=%h id_instr=%h, none expected", id_pc, id_instr);
      end else begin
        e = exp_q.pop_front();
        if (id_pc !== e.pc || id_instr !== e.instr) begin
          n_fail++;
          $display("FAIL delivery: got pc=%h instr=%h want pc=%h instr=%h",
                   id_pc, id_instr, e.pc, e.instr);
        end else begin
          $display("[TB] delivered pc=%h instr=%h", id_pc, id_instr);
        end
      end
    end
  endtask

  task automatic cycle();
    #1;
    mem_drive();
    stall_id_edge = stall_id;
    @(negedge clk);
    monitor();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cycle();
    cycle();
    n_tests++;
    if (imem_bus.req_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_req_valid: got %b want 0", imem_bus.req_valid);
    end
    n_tests++;
    if (id_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_id_valid: got %b want 0", id_valid);
    end
    n_tests++;
    if (id_pc !== 32'h0) begin
      n_fail++; $display("FAIL reset_id_pc: got %h want 0", id_pc);
    end
    n_tests++;
    if (id_instr !== 32'h0000_0013) begin
      n_fail++; $display("FAIL reset_id_instr: got %h want 00000013", id_instr);
    end
    rst = 1'b0;
  endtask

  task automatic test_stream();
    push_exp(32'h0);
    push_exp(32'h4);
    for (int i = 0; i < 4; i++) begin
      cycle();
      n_tests++;
      if (imem_bus.req_valid !== ((i % 2) == 1)) begin
        n_fail++; $display("FAIL stream_req_valid[%0d]: got %b want %b", i, imem_bus.req_valid, (i % 2) == 1);
      end
      n_tests++;
      if (id_valid !== ((i % 2) == 1)) begin
        n_fail++; $display("FAIL stream_id_valid[%0d]: got %b want %b", i, id_valid, (i % 2) == 1);
      end
      if ((i % 2) == 1) begin
        n_tests++;
        if (imem_bus.req_addr !== 32'(4 * (i / 2 + 1))) begin
          n_fail++; $display("FAIL stream_addr[%0d]: got %h want %h", i, imem_bus.req_addr, 4 * (i / 2 + 1));
        end
      end
    end
  endtask

  task automatic test_stall_hold();
    push_exp(32'h8);
    cycle();
    stall_id = 1'b1;
    for (int k = 0; k < 3; k++) begin
      cycle();
      n_tests++;
      if (imem_bus.req_valid !== 1'b0 || id_valid !== 1'b0 || id_pc !== 32'h4) begin
        n_fail++;
        $display("FAIL hold[%0d]: got req_valid=%b id_valid=%b id_pc=%h want 0 0 00000004",
                 k, imem_bus.req_valid, id_valid, id_pc);
      end
    end
    stall_id = 1'b0;
    cycle();
    n_tests++;
    if (id_valid !== 1'b1 || imem_bus.req_valid !== 1'b1 || imem_bus.req_addr !== 32'hC) begin
      n_fail++;
      $display("FAIL hold_release: got id_valid=%b req_valid=%b addr=%h want 1 1 0000000c",
               id_valid, imem_bus.req_valid, imem_bus.req_addr);
    end
  endtask

  task automatic test_redirect_flush();
    push_exp(32'hC);
    cycle();
    cycle();
    n_tests++;
    if (imem_bus.req_addr !== 32'h10) begin
      n_fail++; $display("FAIL flush_pre_addr: got %h want 00000010", imem_bus.req_addr);
    end
    mem_lat  = 3;
    stall_id = 1'b1;
    cycle();
    n_tests++;
    if (id_valid !== 1'b1 || imem_bus.req_valid !== 1'b0) begin
      n_fail++; $display("FAIL flush_held: got id_valid=%b req_valid=%b want 1 0", id_valid, imem_bus.req_valid);
    end
    stall_id       = 1'b0;
    redirect_valid = 1'b1;
    flush_if       = 1'b1;
    redirect_pc    = 32'h200;
    cycle();
    redirect_valid = 1'b0;
    flush_if       = 1'b0;
    n_tests++;
    if (id_valid !== 1'b0 || imem_bus.req_valid !== 1'b0 || imem_bus.req_addr !== 32'h200) begin
      n_fail++;
      $display("FAIL flush_apply: got id_valid=%b req_valid=%b addr=%h want 0 0 00000200",
               id_valid, imem_bus.req_valid, imem_bus.req_addr);
    end
    cycle();
    n_tests++;
    if (imem_bus.req_valid !== 1'b0) begin
      n_fail++; $display("FAIL flush_discard_wait: got req_valid=%b want 0", imem_bus.req_valid);
    end
    cycle();
    n_tests++;
    if (imem_bus.req_valid !== 1'b1 || imem_bus.req_addr !== 32'h200 || id_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_restart: got req_valid=%b addr=%h id_valid=%b want 1 00000200 0",
               imem_bus.req_valid, imem_bus.req_addr, id_valid);
    end
    mem_lat = 1;
  endtask

  task automatic test_redirect_on_accept();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h303;
    cycle();
    redirect_valid = 1'b0;
    n_tests++;
    if (imem_bus.req_valid !== 1'b0 || imem_bus.req_addr !== 32'h300) begin
      n_fail++; $display("FAIL accept_redirect: got req_valid=%b addr=%h want 0 00000300",
                         imem_bus.req_valid, imem_bus.req_addr);
    end
    cycle();
    n_tests++;
    if (imem_bus.req_valid !== 1'b1 || imem_bus.req_addr !== 32'h300 || id_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL accept_discard: got req_valid=%b addr=%h id_valid=%b want 1 00000300 0",
               imem_bus.req_valid, imem_bus.req_addr, id_valid);
    end
    push_exp(32'h300);
    cycle();
    cycle();
    n_tests++;
    if (id_valid !== 1'b1 || imem_bus.req_addr !== 32'h304) begin
      n_fail++; $display("FAIL accept_resume: got id_valid=%b addr=%h want 1 00000304", id_valid, imem_bus.req_addr);
    end
  endtask

  task automatic test_wrap();
    mem_ready      = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFC;
    cycle();
    redirect_valid = 1'b0;
    mem_ready      = 1'b1;
    n_tests++;
    if (imem_bus.req_valid !== 1'b1 || imem_bus.req_addr !== 32'hFFFF_FFFC) begin
      n_fail++; $display("FAIL wrap_redirect: got req_valid=%b addr=%h want 1 fffffffc",
                         imem_bus.req_valid, imem_bus.req_addr);
    end
    push_exp(32'hFFFF_FFFC);
    cycle();
    cycle();
    n_tests++;
    if (imem_bus.req_valid !== 1'b1 || imem_bus.req_addr !== 32'h0) begin
      n_fail++; $display("FAIL wrap_addr: got req_valid=%b addr=%h want 1 00000000",
                         imem_bus.req_valid, imem_bus.req_addr);
    end
  endtask

  task automatic test_reset_mid();
    push_exp(32'h0);
    cycle();
    cycle();
    cycle();
    n_tests++;
    if (imem_bus.req_valid !== 1'b0 || imem_bus.req_addr !== 32'h4) begin
      n_fail++; $display("FAIL midrst_pre: got req_valid=%b addr=%h want 0 00000004",
                         imem_bus.req_valid, imem_bus.req_addr);
    end
    rst = 1'b1;
    cycle();
    n_tests++;
    if (imem_bus.req_valid !== 1'b0 || imem_bus.req_addr !== 32'h0 || id_valid !== 1'b0 ||
        id_pc !== 32'h0 || id_instr !== 32'h0000_0013) begin
      n_fail++;
      $display("FAIL midrst_state: got req_valid=%b addr=%h id_valid=%b id_pc=%h id_instr=%h want 0 0 0 0 13",
               imem_bus.req_valid, imem_bus.req_addr, id_valid, id_pc, id_instr);
    end
    rst = 1'b0;
    push_exp(32'h0);
    cycle();
    n_tests++;
    if (imem_bus.req_valid !== 1'b0) begin
      n_fail++; $display("FAIL midrst_accept: got req_valid=%b want 0", imem_bus.req_valid);
    end
    cycle();
    n_tests++;
    if (id_valid !== 1'b1 || imem_bus.req_addr !== 32'h4) begin
      n_fail++; $display("FAIL midrst_resume: got id_valid=%b addr=%h want 1 00000004", id_valid, imem_bus.req_addr);
    end
  endtask

  initial begin
    rst                 = 1'b1;
    stall_if            = 1'b0;
    stall_id            = 1'b0;
    flush_if            = 1'b0;
    redirect_valid      = 1'b0;
    redirect_pc         = '0;
    imem_bus.req_ready  = 1'b0;
    imem_bus.resp_valid = 1'b0;
    imem_bus.resp_data  = '0;

    test_reset();
    test_stream();
    test_stall_hold();
    test_redirect_flush();
    test_redirect_on_accept();
    test_wrap();
    test_reset_mid();

    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++; $display("FAIL leftover_expected: got %0d pending want 0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
